// File: rtl/sysbus_arbiter.sv
// ---------------------------------------------------------------------------
// sysbus_arbiter
//
// Purpose:
//   Two-master round-robin arbiter and address decoder for the 32-bit system
//   bus. The winning master's qualifiers are forwarded onto the shared bus
//   and its address is decoded into a one-hot chip enable. The addressed
//   slave's grant and read data are returned to that master only. Unmapped
//   addresses and slaves that never answer are ended with an error pulse.
//
// Ports:
//   clk_i        system clock
//   rst_ni       synchronous active-low reset
//   mN_req_i     master N request, held with its qualifiers until mN_gnt_o
//   mN_addr_i    master N byte address
//   mN_wdata_i   master N write data
//   mN_we_i      master N write (1) / read (0)
//   mN_hb_i      master N access size (00 byte, 01 half, 10 word)
//   mN_gnt_o     master N one-cycle transfer-complete pulse
//   mN_err_o     master N error flag, qualified by mN_gnt_o
//   mN_rdata_o   master N read data, valid while mN_gnt_o is high
//   bus_addr_o   owner's address while a transfer is in progress
//   bus_wdata_o  owner's write data while a transfer is in progress
//   bus_we_o     write strobe
//   bus_re_o     read strobe
//   bus_hb_o     owner's access size
//   bus_req_o    high while a transfer is in progress
//   bus_ce_o     one-hot slave select
//   s_gnt_i      per-slave grant, bit k from slave k
//   s_rdata_i    per-slave read data, slave k on bits [32k+31:32k]
// ---------------------------------------------------------------------------
module sysbus_arbiter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic         clk_i,
    input  logic         rst_ni,

    input  logic         m0_req_i,
    input  logic [31:0]  m0_addr_i,
    input  logic [31:0]  m0_wdata_i,
    input  logic         m0_we_i,
    input  logic [1:0]   m0_hb_i,
    output logic         m0_gnt_o,
    output logic         m0_err_o,
    output logic [31:0]  m0_rdata_o,

    input  logic         m1_req_i,
    input  logic [31:0]  m1_addr_i,
    input  logic [31:0]  m1_wdata_i,
    input  logic         m1_we_i,
    input  logic [1:0]   m1_hb_i,
    output logic         m1_gnt_o,
    output logic         m1_err_o,
    output logic [31:0]  m1_rdata_o,

    output logic [31:0]  bus_addr_o,
    output logic [31:0]  bus_wdata_o,
    output logic         bus_we_o,
    output logic         bus_re_o,
    output logic [1:0]   bus_hb_o,
    output logic         bus_req_o,
    output logic [7:0]   bus_ce_o,

    input  logic [7:0]   s_gnt_i,
    input  logic [255:0] s_rdata_i
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ERR    = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        ownReq;
    logic [31:0] ownAddr;
    logic [31:0] ownWdata;
    logic        ownWe;
    logic [1:0]  ownHb;
    logic [2:0]  slaveIdx;
    logic        slaveMapped;
    logic        slaveGnt;
    logic [31:0] slaveRdata;

    logic        xferGnt;
    logic        xferErr;
    logic [31:0] xferRdata;

    // Select the current owner's request and qualifiers. Address bit 31 set
    // means region 8..15, none of which has a slave behind it.
    always_comb begin
        ownReq      = owner_q ? m1_req_i   : m0_req_i;
        ownAddr     = owner_q ? m1_addr_i  : m0_addr_i;
        ownWdata    = owner_q ? m1_wdata_i : m0_wdata_i;
        ownWe       = owner_q ? m1_we_i    : m0_we_i;
        ownHb       = owner_q ? m1_hb_i    : m0_hb_i;
        slaveIdx    = ownAddr[30:28];
        slaveMapped = ~ownAddr[31];
        slaveGnt    = s_gnt_i[slaveIdx];
        slaveRdata  = s_rdata_i[{slaveIdx, 5'b00000} +: 32];
    end

    // State, owner, fairness and timeout registers.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            tmo_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            tmo_q   <= tmo_d;
        end
    end

    // Next-state and output logic. An owner that drops its request is
    // treated as an abort and takes precedence over a same-cycle slave
    // grant, so a master never sees a pulse for a transfer it withdrew.
    // A slave grant in the final timeout cycle still completes normally.
    // All outputs are forced low while reset is asserted so nothing leaks
    // out of the cycle in which reset arrives mid-transfer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        tmo_d       = tmo_q;
        xferGnt     = 1'b0;
        xferErr     = 1'b0;
        xferRdata   = 32'd0;
        bus_addr_o  = 32'd0;
        bus_wdata_o = 32'd0;
        bus_we_o    = 1'b0;
        bus_re_o    = 1'b0;
        bus_hb_o    = 2'b00;
        bus_req_o   = 1'b0;
        bus_ce_o    = 8'd0;

        case (state_q)
            IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    owner_d = (m0_req_i && m1_req_i) ? ~last_q : m1_req_i;
                    tmo_d   = 8'd0;
                    state_d = ACCESS;
                end
            end

            ACCESS: begin
                bus_addr_o  = ownAddr;
                bus_wdata_o = ownWdata;
                bus_we_o    = ownWe;
                bus_re_o    = ~ownWe;
                bus_hb_o    = ownHb;
                bus_req_o   = 1'b1;
                bus_ce_o    = slaveMapped ? (8'h01 << slaveIdx) : 8'h00;

                if (!ownReq) begin
                    state_d = IDLE;
                end else if (!slaveMapped) begin
                    state_d = ERR;
                end else if (slaveGnt) begin
                    xferGnt   = 1'b1;
                    xferRdata = slaveRdata;
                    last_d    = owner_q;
                    state_d   = IDLE;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = ERR;
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end

            ERR: begin
                xferGnt = 1'b1;
                xferErr = 1'b1;
                last_d  = owner_q;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        m0_gnt_o   = xferGnt & ~owner_q;
        m0_err_o   = xferErr & ~owner_q;
        m0_rdata_o = owner_q ? 32'd0 : xferRdata;
        m1_gnt_o   = xferGnt & owner_q;
        m1_err_o   = xferErr & owner_q;
        m1_rdata_o = owner_q ? xferRdata : 32'd0;

        if (!rst_ni) begin
            m0_gnt_o    = 1'b0;
            m0_err_o    = 1'b0;
            m0_rdata_o  = 32'd0;
            m1_gnt_o    = 1'b0;
            m1_err_o    = 1'b0;
            m1_rdata_o  = 32'd0;
            bus_addr_o  = 32'd0;
            bus_wdata_o = 32'd0;
            bus_we_o    = 1'b0;
            bus_re_o    = 1'b0;
            bus_hb_o    = 2'b00;
            bus_req_o   = 1'b0;
            bus_ce_o    = 8'd0;
        end
    end

endmodule

// File: tb/tb_sysbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sysbus_arbiter
//
// Purpose:
//   Self-checking bench for sysbus_arbiter. Two master processes issue
//   transfers; every issued transfer pushes its predicted outcome onto that
//   master's queue. A monitor pops and compares whenever a grant appears.
//   Slaves are modelled as "answer after N cycles of being selected".
// ---------------------------------------------------------------------------
module tb_sysbus_arbiter;

    localparam int TB_TIMEOUT = 4;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          run;
        logic [7:0]  ce;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [1:0]  hb;
    } item_t;

    logic         clk;
    logic         rstN;

    logic         mReq   [2];
    logic [31:0]  mAddr  [2];
    logic [31:0]  mWdata [2];
    logic         mWe    [2];
    logic [1:0]   mHb    [2];

    logic         m0_gnt_o, m0_err_o, m1_gnt_o, m1_err_o;
    logic [31:0]  m0_rdata_o, m1_rdata_o;
    logic [31:0]  bus_addr_o, bus_wdata_o;
    logic         bus_we_o, bus_re_o, bus_req_o;
    logic [1:0]   bus_hb_o;
    logic [7:0]   bus_ce_o;
    logic [7:0]   sGnt;
    logic [255:0] sRdata;

    int           ws        [8];
    int           cnt       [8];
    logic [31:0]  slaveData [8];
    logic [7:0]   noise;

    item_t        expQ0 [$];
    item_t        expQ1 [$];
    int           orderQ [$];

    int           checks;
    int           failures;
    int           cycle;
    int           accessRun;
    bit           periodOn;
    bit           prevValid;
    int           prevCycle;

    sysbus_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
        .clk_i       (clk),
        .rst_ni      (rstN),
        .m0_req_i    (mReq[0]),
        .m0_addr_i   (mAddr[0]),
        .m0_wdata_i  (mWdata[0]),
        .m0_we_i     (mWe[0]),
        .m0_hb_i     (mHb[0]),
        .m0_gnt_o    (m0_gnt_o),
        .m0_err_o    (m0_err_o),
        .m0_rdata_o  (m0_rdata_o),
        .m1_req_i    (mReq[1]),
        .m1_addr_i   (mAddr[1]),
        .m1_wdata_i  (mWdata[1]),
        .m1_we_i     (mWe[1]),
        .m1_hb_i     (mHb[1]),
        .m1_gnt_o    (m1_gnt_o),
        .m1_err_o    (m1_err_o),
        .m1_rdata_o  (m1_rdata_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_we_o    (bus_we_o),
        .bus_re_o    (bus_re_o),
        .bus_hb_o    (bus_hb_o),
        .bus_req_o   (bus_req_o),
        .bus_ce_o    (bus_ce_o),
        .s_gnt_i     (sGnt),
        .s_rdata_i   (sRdata)
    );

    // Free-running clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    // Slave k grants once it has been selected for ws[k] earlier cycles.
    // Unselected slaves toggle their grant randomly to exercise gating.
    for (genvar k = 0; k < 8; k++) begin : gSlave
        assign sGnt[k] = bus_ce_o[k] ? (cnt[k] >= ws[k]) : noise[k];
        assign sRdata[32*k +: 32] = slaveData[k];

        always @(posedge clk) begin
            if (bus_req_o && bus_ce_o[k]) cnt[k] <= cnt[k] + 1;
            else                          cnt[k] <= 0;
        end
    end

    // Random grant noise, changed away from the active edge.
    initial begin
        noise = 8'h00;
        forever begin
            @(negedge clk);
            #1 noise = 8'($urandom);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cycle);
        end
    endtask

    function automatic logic anyOut();
        return m0_gnt_o | m0_err_o | (|m0_rdata_o) | m1_gnt_o | m1_err_o | (|m1_rdata_o)
             | (|bus_addr_o) | (|bus_wdata_o) | bus_we_o | bus_re_o | (|bus_hb_o)
             | bus_req_o | (|bus_ce_o);
    endfunction

    // Reference outcome of one transfer from the address map, the slave
    // latency table and the timeout limit.
    function automatic item_t predict(input logic [31:0] a, input logic we,
                                      input logic [31:0] wd, input logic [1:0] hb);
        item_t it;
        int    k;
        it.addr  = a;
        it.wdata = wd;
        it.we    = we;
        it.hb    = hb;
        k = int'(a[31:28]);
        if (k >= 8) begin
            it.err = 1'b1; it.rdata = 32'd0; it.run = 1; it.ce = 8'h00;
        end else if (ws[k] < TB_TIMEOUT) begin
            it.err = 1'b0; it.rdata = slaveData[k]; it.run = ws[k] + 1; it.ce = 8'(1 << k);
        end else begin
            it.err = 1'b1; it.rdata = 32'd0; it.run = TB_TIMEOUT; it.ce = 8'h00;
        end
        return it;
    endfunction

    // Issue one transfer from master m, hold it until granted, then release.
    task automatic applyStimulus(input int m, input logic [31:0] a, input logic we,
                                 input logic [31:0] wd, input logic [1:0] hb, input int gap);
        item_t it;
        bit    got;
        it = predict(a, we, wd, hb);
        if (m == 0) expQ0.push_back(it);
        else        expQ1.push_back(it);
        mAddr[m]  = a;
        mWdata[m] = wd;
        mWe[m]    = we;
        mHb[m]    = hb;
        mReq[m]   = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if ((m == 0) ? m0_gnt_o : m1_gnt_o) got = 1'b1;
        end
        if (!got) begin
            checks++;
            failures++;
            $display("[TB] FAIL gnt_wait master=%0d actual=no_grant required=grant within 60 cycles", m);
        end
        @(posedge clk);
        #1 mReq[m] = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Compare a grant against the head of the owning master's queue.
    task automatic handleGnt();
        item_t it;
        int    m;
        bit    empty;
        m = m1_gnt_o ? 1 : 0;
        checkOutput("gnt_exclusive", {31'd0, m0_gnt_o & m1_gnt_o}, 32'd0);
        empty = (m == 0) ? (expQ0.size() == 0) : (expQ1.size() == 0);
        if (empty) begin
            checks++;
            failures++;
            $display("[TB] FAIL unexpected_gnt master=%0d actual=1 required=0 at cycle %0d", m, cycle);
        end else begin
            it = (m == 0) ? expQ0.pop_front() : expQ1.pop_front();
            checkOutput("err_flag", {31'd0, (m == 0) ? m0_err_o : m1_err_o}, {31'd0, it.err});
            checkOutput("rdata", (m == 0) ? m0_rdata_o : m1_rdata_o, it.rdata);
            checkOutput("access_cycles", 32'(accessRun), 32'(it.run));
            checkOutput("bus_ce", {24'd0, bus_ce_o}, {24'd0, it.ce});
            checkOutput("bus_req_at_gnt", {31'd0, bus_req_o}, {31'd0, ~it.err});
            checkOutput("other_err", {31'd0, (m == 0) ? m1_err_o : m0_err_o}, 32'd0);
            checkOutput("other_rdata", (m == 0) ? m1_rdata_o : m0_rdata_o, 32'd0);
            if (!it.err) begin
                checkOutput("bus_addr", bus_addr_o, it.addr);
                checkOutput("bus_wdata", bus_wdata_o, it.wdata);
                checkOutput("bus_we_re", {30'd0, bus_we_o, bus_re_o}, {30'd0, it.we, ~it.we});
                checkOutput("bus_hb", {30'd0, bus_hb_o}, {30'd0, it.hb});
            end
        end
        if (orderQ.size() > 0) begin
            checkOutput("grant_order", 32'(m), 32'(orderQ.pop_front()));
        end
        if (periodOn) begin
            if (prevValid) checkOutput("gnt_period", 32'(cycle - prevCycle), 32'd3);
            prevCycle = cycle;
            prevValid = 1'b1;
        end
    endtask

    // Monitor: tracks the length of each bus_req_o run and checks every
    // grant; outside grants no error flag may be raised.
    always @(negedge clk) begin
        if (!rstN) begin
            accessRun = 0;
        end else begin
            if (bus_req_o) accessRun++;
            if (m0_gnt_o || m1_gnt_o) begin
                handleGnt();
                accessRun = 0;
            end else begin
                if (!bus_req_o) accessRun = 0;
                checkOutput("err_without_gnt", {30'd0, m1_err_o, m0_err_o}, 32'd0);
            end
        end
    end

    // Global guard against a hang anywhere in the sequence.
    initial begin
        #400000;
        $display("[TB] FAIL watchdog actual=still_running required=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Main sequence.
    initial begin
        checks    = 0;
        failures  = 0;
        cycle     = 0;
        accessRun = 0;
        periodOn  = 1'b0;
        prevValid = 1'b0;
        prevCycle = 0;
        rstN      = 1'b0;
        for (int i = 0; i < 2; i++) begin
            mReq[i]   = 1'b0;
            mAddr[i]  = 32'h1234_5678;
            mWdata[i] = 32'hCAFE_0000;
            mWe[i]    = 1'b1;
            mHb[i]    = 2'b10;
        end
        for (int k = 0; k < 8; k++) begin
            ws[k]        = 0;
            cnt[k]       = 0;
            slaveData[k] = $urandom;
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_outputs", {31'd0, anyOut()}, 32'd0);
        rstN = 1'b1;
        #1 checkOutput("post_reset_outputs", {31'd0, anyOut()}, 32'd0);
        @(posedge clk);
        #1;

        // Contention on SRAM with one wait state: m0 first, then strict
        // alternation with three cycles per transfer.
        ws[1] = 1;
        for (int i = 0; i < 3; i++) begin
            orderQ.push_back(0);
            orderQ.push_back(1);
        end
        periodOn  = 1'b1;
        prevValid = 1'b0;
        fork
            begin
                for (int i = 0; i < 3; i++)
                    applyStimulus(0, 32'h1000_0000 + 32'(i * 4), 1'b0, 32'd0, 2'b10, 0);
            end
            begin
                for (int i = 0; i < 3; i++)
                    applyStimulus(1, 32'h1000_0100 + 32'(i * 4), 1'b1, $urandom, 2'b10, 0);
            end
        join
        periodOn = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Directed single transfers.
        slaveData[0] = 32'hDEAD_BEEF;
        ws[0] = 0;
        ws[2] = 2;
        ws[3] = 255;
        applyStimulus(0, 32'h0000_0010, 1'b0, 32'd0, 2'b10, 1);
        applyStimulus(1, 32'h2000_0000, 1'b1, 32'h0000_0041, 2'b00, 1);
        applyStimulus(1, 32'h8000_0000, 1'b0, 32'd0, 2'b10, 1);
        applyStimulus(0, 32'h3000_0000, 1'b0, 32'd0, 2'b10, 1);

        // Reset while master 0 waits on SRAM; the slave becomes ready in the
        // same cycle reset arrives, and no grant may escape.
        ws[1]     = 3;
        mAddr[0]  = 32'h1000_0004;
        mWe[0]    = 1'b0;
        mHb[0]    = 2'b10;
        mReq[0]   = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        #2;
        ws[1] = 0;
        rstN  = 1'b0;
        #1 checkOutput("rst_during_access", {31'd0, anyOut()}, 32'd0);
        @(posedge clk);
        #1 mReq[0] = 1'b0;
        @(negedge clk);
        checkOutput("rst_held", {31'd0, anyOut()}, 32'd0);
        rstN = 1'b1;
        #1 checkOutput("rst_released", {31'd0, anyOut()}, 32'd0);
        @(posedge clk);
        #1;

        // Simultaneous requests after reset: master 0 wins.
        ws[1] = 1;
        orderQ.push_back(0);
        orderQ.push_back(1);
        fork
            applyStimulus(0, 32'h1000_0020, 1'b0, 32'd0, 2'b10, 1);
            applyStimulus(1, 32'h1000_0024, 1'b0, 32'd0, 2'b01, 1);
        join

        // Randomised traffic from both masters with random slave latencies,
        // including slaves slower than the timeout and unmapped regions.
        for (int k = 0; k < 8; k++) begin
            ws[k]        = $urandom_range(0, 5);
            slaveData[k] = $urandom;
        end
        fork
            begin
                for (int i = 0; i < 25; i++)
                    applyStimulus(0, {4'($urandom_range(0, 9)), 28'($urandom)}, 1'($urandom),
                                  $urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 2));
            end
            begin
                for (int i = 0; i < 25; i++)
                    applyStimulus(1, {4'($urandom_range(0, 9)), 28'($urandom)}, 1'($urandom),
                                  $urandom, 2'($urandom_range(0, 2)), $urandom_range(0, 2));
            end
        join

        repeat (5) @(posedge clk);
        @(negedge clk);
        checkOutput("exp_q0_drained", 32'(expQ0.size()), 32'd0);
        checkOutput("exp_q1_drained", 32'(expQ1.size()), 32'd0);
        checkOutput("order_q_drained", 32'(orderQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
